// File: rtl/axis_mem_writer_pkg.sv
// Shared types and default widths for the AXI-Stream memory writer.
package axis_mem_writer_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_MAX_BURST  = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    DRAIN     = 2'd2,
    WAIT_LAST = 2'd3
  } wr_state_e;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axis_mem_writer_fwd_reg.sv
// One-deep valid/ready forward register; holds its payload while the sink stalls.
module axis_mem_writer_fwd_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] data_q;
  logic         valid_q;

  // Can refill in the same cycle the current beat leaves, so no bubble.
  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_mem_writer.sv
// Accepts one AXI-Stream packet per start command and writes it to sequential
// memory addresses from a programmed base, reporting length and error flags.
module axis_mem_writer
  import axis_mem_writer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                    s01_axis_aclk,
  input  logic                    s01_axis_areset,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_addr,
  input  logic                    cfg_start,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  output logic                    m01_axis_wr_en,
  output logic [ADDR_WIDTH-1:0]   m01_axis_wr_addr,
  output logic [DATA_WIDTH-1:0]   m01_axis_wr_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH:0]     pkt_len,
  output logic                    err_wrap,
  output logic                    err_len
);

  localparam int unsigned STRB_W = strb_width(DATA_WIDTH);
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned PAY_W  = ADDR_WIDTH + DATA_WIDTH + STRB_W + 1;

  wr_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  err_wrap_q, err_wrap_d;
  logic                  err_len_q, err_len_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      pkt_len_q, pkt_len_d;

  logic                  fwd_in_ready;
  logic                  fwd_valid;
  logic                  fwd_load;
  logic                  force_last;
  logic                  s_accept;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [CNT_W-1:0]      cnt_inc;
  logic [PAY_W-1:0]      pay_in;
  logic [PAY_W-1:0]      pay_out;

  assign wr_addr_c = base_q + cnt_q[ADDR_WIDTH-1:0];
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // In DRAIN the source is emptied without touching memory.
  assign s01_axis_tready = ((state_q == STREAM) && fwd_in_ready) || (state_q == DRAIN);
  assign s_accept        = s01_axis_tvalid && s01_axis_tready;

  assign pay_in = {wr_addr_c, s01_axis_tdata, s01_axis_tstrb, s01_axis_tlast | force_last};

  axis_mem_writer_fwd_reg #(
    .W (PAY_W)
  ) u_fwd (
    .clk_i       (s01_axis_aclk),
    .rst_i       (s01_axis_areset),
    .in_data_i   (pay_in),
    .in_valid_i  (fwd_load),
    .in_ready_o  (fwd_in_ready),
    .out_data_o  (pay_out),
    .out_valid_o (fwd_valid),
    .out_ready_i (m01_axis_tready)
  );

  assign {m01_axis_wr_addr, m01_axis_wr_tdata, m01_axis_tstrb, m01_axis_tlast} = pay_out;
  assign m01_axis_tvalid = fwd_valid;
  assign m01_axis_wr_en  = fwd_valid;

  assign busy     = busy_q;
  assign done     = done_q;
  assign pkt_len  = pkt_len_q;
  assign err_wrap = err_wrap_q;
  assign err_len  = err_len_q;

  always_ff @(posedge s01_axis_aclk) begin
    if (s01_axis_areset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      err_wrap_q <= 1'b0;
      err_len_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      pkt_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      err_wrap_q <= err_wrap_d;
      err_len_q  <= err_len_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      pkt_len_q  <= pkt_len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    err_wrap_d = err_wrap_q;
    err_len_d  = err_len_q;
    done_d     = 1'b0;
    pkt_len_d  = pkt_len_q;
    fwd_load   = 1'b0;
    force_last = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse still sees the block busy.
        if (cfg_start && !done_q) begin
          base_d     = cfg_base_addr;
          cnt_d      = '0;
          err_wrap_d = 1'b0;
          err_len_d  = 1'b0;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (s_accept) begin
          fwd_load = 1'b1;
          cnt_d    = cnt_inc;
          if ((wr_addr_c == '0) && (cnt_q != '0)) begin
            err_wrap_d = 1'b1;
          end
          if (s01_axis_tlast) begin
            state_d = WAIT_LAST;
          end else if (cnt_inc == CNT_W'(MAX_BURST)) begin
            force_last = 1'b1;
            err_len_d  = 1'b1;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (s_accept && s01_axis_tlast) begin
          state_d = WAIT_LAST;
        end
      end
      WAIT_LAST: begin
        if (!fwd_valid || m01_axis_tready) begin
          done_d    = 1'b1;
          pkt_len_d = cnt_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || done_d;
  end

endmodule
